// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3-style slave backed by an on-chip 32-bit word memory.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs,
// FIXED/INCR/WRAP bursts, byte strobes and SLVERR for malformed or
// out-of-range accesses. Memory contents survive reset.
// Optional build macro AXI_SLV_WAITSTATE_EN: RVALID comes up two cycles after
// the AR handshake and drops for one cycle after every non-final R beat.
module axi_slave_mem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [3:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [3:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [3:0]  WID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [3:0]  BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [3:0]  ARID,
  input  logic [31:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int          LP_AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] LP_MEM_BYTES = 32'(MEM_DEPTH) << 2;
`ifdef AXI_SLV_WAITSTATE_EN
  localparam bit LP_WAIT = 1'b1;
`else
  localparam bit LP_WAIT = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Address of the next beat; WRAP keeps the upper bits of the aligned window.
  function automatic logic [31:0] f_next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [3:0] l, input logic [1:0] b);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << s;
    mask = ((32'(l) + 32'd1) << s) - 32'd1;
    case (b)
      2'b00:   f_next_addr = a;
      2'b10:   f_next_addr = (a & ~mask) | ((a + step) & mask);
      default: f_next_addr = a + step;
    endcase
  endfunction

  // Whole-burst errors: oversize beats, reserved burst type, illegal wrap length.
  function automatic logic f_burst_err(input logic [2:0] s, input logic [3:0] l,
                                       input logic [1:0] b);
    f_burst_err = (s > 3'd2) || (b == 2'b11) ||
                  ((b == 2'b10) && !(l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15));
  endfunction

  function automatic logic f_addr_bad(input logic [31:0] a);
    f_addr_bad = (a >= LP_MEM_BYTES);
  endfunction

  // Write side state
  wstate_t     r_wstate;
  logic        r_awready, r_wready, r_bvalid;
  logic [3:0]  r_bid, r_awid, r_awlen, r_wbeat;
  logic [1:0]  r_bresp, r_awburst;
  logic [2:0]  r_awsize;
  logic [31:0] r_waddr;
  logic        r_wburst_err, r_werr;

  // Read side state
  rstate_t     r_rstate;
  logic        r_arready, r_rvalid, r_rlast, r_rdata_en, r_rburst_err;
  logic [3:0]  r_rid, r_arlen, r_rbeat;
  logic [1:0]  r_rresp, r_arburst;
  logic [2:0]  r_arsize;
  logic [31:0] r_raddr;

  logic             w_aw_hs, w_w_hs, w_wbeat_last, w_wbeat_err, w_wr_en;
  logic [LP_AW-1:0] w_wr_idx, w_rd_idx;
  logic             w_ar_hs, w_r_hs;
  logic [31:0]      w_r_next_addr, w_rd_addr, w_mem_rdata;
  logic             w_rd_launch, w_rd_last, w_rd_err;
  logic             w_unused;

  assign w_unused     = &{1'b0, WID};
  assign w_aw_hs      = AWVALID && r_awready;
  assign w_w_hs       = WVALID && r_wready;
  assign w_wbeat_last = (r_wbeat == r_awlen);
  assign w_wbeat_err  = f_addr_bad(r_waddr) || (WLAST != w_wbeat_last);
  assign w_wr_en      = w_w_hs && !r_wburst_err && !w_wbeat_err;
  assign w_wr_idx     = r_waddr[LP_AW+1:2];

  // Write FSM: accept AW, take LEN+1 beats (erroneous ones are dropped), hold B until BREADY.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate     <= W_IDLE;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bid        <= '0;
      r_bresp      <= '0;
      r_awid       <= '0;
      r_awlen      <= '0;
      r_awsize     <= '0;
      r_awburst    <= '0;
      r_waddr      <= '0;
      r_wbeat      <= '0;
      r_wburst_err <= 1'b0;
      r_werr       <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awready    <= 1'b0;
            r_wready     <= 1'b1;
            r_awid       <= AWID;
            r_waddr      <= AWADDR;
            r_awlen      <= AWLEN;
            r_awsize     <= AWSIZE;
            r_awburst    <= AWBURST;
            r_wbeat      <= '0;
            r_wburst_err <= f_burst_err(AWSIZE, AWLEN, AWBURST);
            r_werr       <= f_burst_err(AWSIZE, AWLEN, AWBURST);
            r_wstate     <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_waddr <= f_next_addr(r_waddr, r_awsize, r_awlen, r_awburst);
            r_wbeat <= r_wbeat + 4'd1;
            r_werr  <= r_werr | w_wbeat_err;
            if (w_wbeat_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_awid;
              r_bresp  <= (r_werr || w_wbeat_err) ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_ar_hs       = ARVALID && r_arready;
  assign w_r_hs        = r_rvalid && RREADY;
  assign w_r_next_addr = f_next_addr(r_raddr, r_arsize, r_arlen, r_arburst);
  assign w_rd_idx      = w_rd_addr[LP_AW+1:2];

  // Decide when a read beat is launched (memory read + R register load) and its attributes.
  always_comb begin
    w_rd_launch = 1'b0;
    w_rd_addr   = r_raddr;
    w_rd_last   = 1'b0;
    w_rd_err    = 1'b0;
    if (LP_WAIT) begin
      w_rd_launch = (r_rstate == R_DATA) && !r_rvalid;
      w_rd_last   = (r_rbeat == r_arlen);
      w_rd_err    = r_rburst_err || f_addr_bad(r_raddr);
    end else if (w_ar_hs) begin
      w_rd_launch = 1'b1;
      w_rd_addr   = ARADDR;
      w_rd_last   = (ARLEN == 4'd0);
      w_rd_err    = f_burst_err(ARSIZE, ARLEN, ARBURST) || f_addr_bad(ARADDR);
    end else if ((r_rstate == R_DATA) && w_r_hs && !r_rlast) begin
      w_rd_launch = 1'b1;
      w_rd_addr   = w_r_next_addr;
      w_rd_last   = ((r_rbeat + 4'd1) == r_arlen);
      w_rd_err    = r_rburst_err || f_addr_bad(w_r_next_addr);
    end
  end

  // Read FSM: latch AR, step beats on each R handshake, load R outputs on every launch.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate     <= R_IDLE;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rlast      <= 1'b0;
      r_rid        <= '0;
      r_rresp      <= '0;
      r_rdata_en   <= 1'b0;
      r_raddr      <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_rbeat      <= '0;
      r_rburst_err <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready    <= 1'b0;
            r_rid        <= ARID;
            r_raddr      <= ARADDR;
            r_arlen      <= ARLEN;
            r_arsize     <= ARSIZE;
            r_arburst    <= ARBURST;
            r_rbeat      <= '0;
            r_rburst_err <= f_burst_err(ARSIZE, ARLEN, ARBURST);
            r_rstate     <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_r_next_addr;
              r_rbeat <= r_rbeat + 4'd1;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
      if (w_rd_launch) begin
        r_rvalid   <= 1'b1;
        r_rlast    <= w_rd_last;
        r_rresp    <= w_rd_err ? 2'b10 : 2'b00;
        r_rdata_en <= !w_rd_err;
      end
    end
  end

  // One memory per byte lane so strobed writes stay simple; read-first on collisions.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [MEM_DEPTH];
      logic [7:0] r_q;
      // Byte-lane write and registered read
      always_ff @(posedge ACLK) begin
        if (w_wr_en && WSTRB[gi]) r_mem[w_wr_idx] <= WDATA[gi*8 +: 8];
        if (w_rd_launch) r_q <= r_mem[w_rd_idx];
      end
      assign w_mem_rdata[gi*8 +: 8] = r_q;
    end
  endgenerate

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_bid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RID     = r_rid;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata_en ? w_mem_rdata : 32'd0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed testbench for axi_slave_mem: bursts, strobes, errors, stalls, reset.
module tb_axi_slave_mem;
  localparam int DEPTH = 256;
`ifdef AXI_SLV_WAITSTATE_EN
  localparam int FIRST = 1;
  localparam int GAP   = 2;
`else
  localparam int FIRST = 0;
  localparam int GAP   = 1;
`endif

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic [3:0]  AWID, AWLEN, WID, ARID, ARLEN, BID, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_slave_mem #(.MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstr [16];
  logic [31:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  int          rcyc [16];
  logic [3:0]  rid_seen;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;
  logic [31:0] exp_wrap [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full write burst; called on a negedge. bstall = cycles BREADY is held low with B pending.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bad_last,
                           input int bstall, output logic [1:0] bresp, output logic [3:0] bid);
    int t;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) check("aw_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WID = id; WDATA = wdat[b]; WSTRB = wstr[b];
      WLAST = (b == int'(len)) ^ bad_last;
      WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
      if (t >= 50) check("w_timeout", 32'd0, 32'd1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) check("b_timeout", 32'd0, 32'd1);
    for (int k = 0; k < bstall; k++) begin
      check("b_stall_valid", 32'(BVALID), 32'd1);
      check("b_stall_bid", 32'(BID), 32'(id));
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    bresp = BRESP; bid = BID;
    @(negedge ACLK);
    BREADY = 1'b0;
    $display("[TB] write id=%0d addr=0x%08h len=%0d size=%0d burst=%0d bresp=%0d bid=%0d",
             id, addr, len, size, burst, bresp, bid);
  endtask

  // Full read burst with RREADY held high; records data, resp, last and arrival cycle.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t, n, cyc;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1; RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) check("ar_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0; cyc = 0;
    while (n <= int'(len) && cyc < 100) begin
      if (RVALID) begin
        rdat[n] = RDATA; rrsp[n] = RRESP; rlst[n] = RLAST; rcyc[n] = cyc;
        if (n == 0) rid_seen = RID;
        n++;
      end
      @(negedge ACLK);
      cyc++;
    end
    if (n <= int'(len)) check("r_timeout", 32'(n), 32'(len) + 32'd1);
    RREADY = 1'b0;
    $display("[TB] read  id=%0d addr=0x%08h len=%0d burst=%0d rdata0=0x%08h rresp0=%0d",
             id, addr, len, burst, rdat[0], rrsp[0]);
  endtask

  initial begin
    int t;
    logic [31:0] v;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
    exp_wrap[0] = 32'hA2; exp_wrap[1] = 32'hA3; exp_wrap[2] = 32'hA0; exp_wrap[3] = 32'hA1;

    // Reset state and first-ready timing
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    ARESETn = 1'b1;
    #1;
    check("rel_awready_early", 32'(AWREADY), 32'd0);
    @(negedge ACLK);
    check("rel_awready", 32'(AWREADY), 32'd1);
    check("rel_arready", 32'(ARREADY), 32'd1);

    // INCR write then read back, with beat timing
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstr[i] = 4'hF; end
    axi_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    check("incr_bresp", 32'(bresp_q), 32'd0);
    check("incr_bid", 32'(bid_q), 32'd5);
    axi_read(4'd9, 32'h10, 4'd3, 3'd2, 2'b01);
    check("incr_rid", 32'(rid_seen), 32'd9);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rdat[i], 32'hA0 + 32'(i));
      check($sformatf("incr_rlast%0d", i), 32'(rlst[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    check("incr_rresp", 32'(rrsp[3]), 32'd0);
    check("incr_first_cyc", 32'(rcyc[0]), 32'(FIRST));
    check("incr_last_cyc", 32'(rcyc[3]), 32'(FIRST + 3 * GAP));

    // WRAP read: 0x18, 0x1C, 0x10, 0x14
    axi_read(4'd2, 32'h18, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_rdata%0d", i), rdat[i], exp_wrap[i]);
    check("wrap_rlast", 32'(rlst[3]), 32'd1);

    // Partial strobe
    wdat[0] = 32'h11223344; wstr[0] = 4'hF;
    axi_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    wdat[0] = 32'hDEADBEEF; wstr[0] = 4'h3;
    axi_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    axi_read(4'd1, 32'h40, 4'd0, 3'd2, 2'b01);
    check("strb_rdata", rdat[0], 32'h1122BEEF);

    // FIXED burst: both beats land on one word, the last one wins
    wdat[0] = 32'h1; wdat[1] = 32'h2; wstr[0] = 4'hF; wstr[1] = 4'hF;
    axi_write(4'd4, 32'h50, 4'd1, 3'd2, 2'b00, 1'b0, 0, bresp_q, bid_q);
    check("fixed_bresp", 32'(bresp_q), 32'd0);
    axi_read(4'd4, 32'h50, 4'd0, 3'd2, 2'b01);
    check("fixed_rdata", rdat[0], 32'h2);

    // Out-of-range write/read
    wdat[0] = 32'h13579BDF; wstr[0] = 4'hF;
    axi_write(4'd6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    wdat[0] = 32'hFFFFFFFF;
    axi_write(4'd6, 32'(DEPTH * 4), 4'd0, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    check("oor_bresp", 32'(bresp_q), 32'd2);
    axi_read(4'd6, 32'h0, 4'd0, 3'd2, 2'b01);
    check("oor_mem_kept", rdat[0], 32'h13579BDF);
    axi_read(4'd6, 32'(DEPTH * 4), 4'd0, 3'd2, 2'b01);
    check("oor_rresp", 32'(rrsp[0]), 32'd2);
    check("oor_rdata", rdat[0], 32'd0);

    // Oversize beat
    wdat[0] = 32'h12345678;
    axi_write(4'd8, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0, 0, bresp_q, bid_q);
    wdat[0] = 32'hFFFFFFFF;
    axi_write(4'd8, 32'h20, 4'd0, 3'd3, 2'b01, 1'b0, 0, bresp_q, bid_q);
    check("size3_bresp", 32'(bresp_q), 32'd2);
    axi_read(4'd8, 32'h20, 4'd0, 3'd2, 2'b01);
    check("size3_mem_kept", rdat[0], 32'h12345678);

    // WLAST misplaced, illegal WRAP length
    wdat[1] = 32'h0; wstr[1] = 4'hF;
    axi_write(4'd3, 32'h30, 4'd1, 3'd2, 2'b01, 1'b1, 0, bresp_q, bid_q);
    check("wlast_bresp", 32'(bresp_q), 32'd2);
    wdat[2] = 32'h0; wstr[2] = 4'hF;
    axi_write(4'd3, 32'h30, 4'd2, 3'd2, 2'b10, 1'b0, 0, bresp_q, bid_q);
    check("wraplen_bresp", 32'(bresp_q), 32'd2);

    // BREADY stall: BVALID/BID must hold
    wdat[0] = 32'h77; wstr[0] = 4'hF;
    axi_write(4'd7, 32'h70, 4'd0, 3'd2, 2'b01, 1'b0, 4, bresp_q, bid_q);
    check("bstall_bid", 32'(bid_q), 32'd7);

    // RREADY stall on the second beat of the INCR burst at 0x10
    ARID = 4'hA; ARADDR = 32'h10; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 50) begin @(negedge ACLK); t++; end
    check("rstall_beat0", RDATA, 32'hA0);
    @(negedge ACLK);
    RREADY = 1'b0;
    t = 0;
    while (!RVALID && t < 50) begin @(negedge ACLK); t++; end
    for (int k = 0; k < 5; k++) begin
      check("rstall_valid", 32'(RVALID), 32'd1);
      check("rstall_rdata", RDATA, 32'hA1);
      check("rstall_rlast", 32'(RLAST), 32'd0);
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    t = 0; v = 32'd0;
    while (t < 50) begin
      if (RVALID && RLAST) begin v = RDATA; break; end
      @(negedge ACLK); t++;
    end
    check("rstall_final", v, 32'hA3);
    @(negedge ACLK);
    RREADY = 1'b0;
    $display("[TB] read  id=10 addr=0x00000010 len=3 with RREADY stall");

    // Reset in the middle of a write and a stalled read
    AWID = 4'h3; AWADDR = 32'h60; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 4'hC; ARADDR = 32'h10; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    t = 0;
    while (!(AWREADY && ARREADY) && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    AWVALID = 1'b0; ARVALID = 1'b0;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    @(negedge ACLK);
    check("pre_rst_rvalid", 32'(RVALID), 32'd1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_awready", 32'(AWREADY), 32'd0);
    check("mid_rst_wready", 32'(WREADY), 32'd0);
    check("mid_rst_bvalid", 32'(BVALID), 32'd0);
    check("mid_rst_bid", 32'(BID), 32'd0);
    check("mid_rst_arready", 32'(ARREADY), 32'd0);
    check("mid_rst_rvalid", 32'(RVALID), 32'd0);
    check("mid_rst_rid", 32'(RID), 32'd0);
    check("mid_rst_rdata", RDATA, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("post_rst_awready_early", 32'(AWREADY), 32'd0);
    @(negedge ACLK);
    check("post_rst_awready", 32'(AWREADY), 32'd1);
    check("post_rst_bvalid", 32'(BVALID), 32'd0);
    $display("[TB] reset pulsed during write id=3 addr=0x00000060");
    axi_read(4'd3, 32'h60, 4'd0, 3'd2, 2'b01);
    check("post_rst_mem_kept", rdat[0], 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit memory words (word index = ADDR[log2(MEM_DEPTH)+1:2]).
REQ-002 SHALL have port ACLK, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, input, 4/32/4/3/2/1, write address channel.
REQ-005 SHALL have port AWREADY, output, 1, write address accept.
REQ-006 SHALL have ports WID/WDATA/WSTRB/WLAST/WVALID, input, 4/32/4/1/1, write data channel.
REQ-007 SHALL have port WREADY, output, 1, write data accept.
REQ-008 SHALL have ports BID/BRESP/BVALID, output, 4/2/1, write response; BREADY, input, 1.
REQ-009 SHALL have ports ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID, input, 4/32/4/3/2/1, read address; ARREADY, output, 1.
REQ-010 SHALL have ports RID/RDATA/RRESP/RLAST/RVALID, output, 4/32/2/1/1, read data; RREADY, input, 1.

Function
REQ-011 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-012 AW handshake SHALL latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear beat counter, and enter W_DATA next cycle.
REQ-013 Each W handshake SHALL write byte lane n of the current word only where WSTRB[n]=1, then advance address and beat counter.
REQ-014 Address advance SHALL be: FIXED(00) unchanged; INCR(01) +2^SIZE; WRAP(10) +2^SIZE wrapping within an aligned (LEN+1)*2^SIZE boundary; 32-bit arithmetic, carry discarded.
REQ-015 After beat LEN+1 is accepted the FSM SHALL enter W_RESP next cycle with BID=latched AWID; BVALID SHALL hold with BID/BRESP stable until BREADY, then return to W_IDLE.
REQ-016 BRESP SHALL be SLVERR(10) if SIZE>2, BURST=11, WRAP with LEN not in {1,3,7,15}, any beat address >= MEM_DEPTH*4, or WLAST mismatching the final-beat position; else OKAY(00); on an error condition memory SHALL NOT be written for the offending beat(s), but all LEN+1 beats SHALL still be accepted.
REQ-017 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; AR handshake latches AR fields; RVALID SHALL rise the next cycle.
REQ-018 RDATA SHALL be registered from memory when each beat is launched; RID/RDATA/RRESP/RLAST SHALL stay stable while RVALID=1 and RREADY=0.
REQ-019 Successive read beats SHALL be issued back-to-back (one per cycle while RREADY=1); RLAST=1 on beat LEN+1 only; after its handshake return to R_IDLE.
REQ-020 Read errors per REQ-016 rules (excluding WLAST) SHALL give RRESP=SLVERR and RDATA=0 for affected beats; bursts SHALL still complete LEN+1 beats.
REQ-021 Read and write FSMs SHALL run independently; a read beat launched in the same cycle as a write to the same word SHALL return the pre-write data.
REQ-022 WID SHALL be ignored for data routing (single outstanding write).

Reset
REQ-023 While ARESETn=0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST=0; BID, BRESP, RID, RRESP, RDATA=0; FSMs in W_IDLE/R_IDLE.
REQ-024 AWREADY and ARREADY SHALL first assert on the first ACLK rising edge after ARESETn deasserts.
REQ-025 Reset mid-burst SHALL abort the transaction with no response issued; memory contents SHALL NOT be reset.

Configuration
REQ-026 With macro AXI_SLV_WAITSTATE_EN defined, RVALID SHALL rise two cycles after AR handshake and drop for exactly one cycle after every non-final R handshake; without it, REQ-017/REQ-019 timing applies.

Verification
REQ-027 INCR write AWADDR=0x10, LEN=3, SIZE=2, data 0xA0..0xA3, WSTRB=F -> BRESP=00, BID=AWID; INCR read same -> RDATA 0xA0..0xA3, RLAST on beat 4.
REQ-028 WRAP read ARADDR=0x18, LEN=3, SIZE=2 -> beat addresses 0x18,0x1C,0x10,0x14.
REQ-029 Write WSTRB=0x3, WDATA=0xDEADBEEF over word 0x11223344 -> read returns 0x1122BEEF.
REQ-030 AWADDR=MEM_DEPTH*4, LEN=0 -> BRESP=10, memory unchanged; AWSIZE=3 -> BRESP=10.
REQ-031 RREADY held 0 for 5 cycles mid-burst -> RDATA/RLAST stable; BREADY held 0 -> BVALID/BID stable; ARESETn pulsed mid-burst -> all outputs per REQ-023, AWREADY=1 one cycle after release.
